// File: rtl/hard_mem_1rw_tiled_wrapper.sv
// Single-port memory wrapper that tiles 8x1024 sky130 SRAM macros in width and depth,
// with valid/ready requests and a valid/yumi read response. Optional macro: HARD_MEM_WRITE_ACK_EN.

// Behavioural stand-in for the hard macro: registered access, read data valid the cycle after.
module sky130_sram_1kbyte_1rw1r_8x1024_8 (
  input  logic       clk0,
  input  logic       csb0,
  input  logic       web0,
  input  logic [0:0] wmask0,
  input  logic [9:0] addr0,
  input  logic [7:0] din0,
  output logic [7:0] dout0,
  input  logic       clk1,
  input  logic       csb1,
  input  logic [9:0] addr1,
  output logic [7:0] dout1
);
  logic [7:0] mem [1024];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        if (wmask0[0]) mem[addr0] <= din0;
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end
endmodule

module hard_mem_1rw_tiled_wrapper #(
  parameter int DATA_WIDTH       = 46,
  parameter int ADDR_WIDTH       = 10,
  parameter int MACRO_WIDTH      = 8,
  parameter int MACRO_ADDR_WIDTH = 10,
  parameter int MASK_WIDTH       = (DATA_WIDTH + MACRO_WIDTH - 1) / MACRO_WIDTH,
  parameter int NUM_BANKS        = 2 ** (ADDR_WIDTH - MACRO_ADDR_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic                  w_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [MASK_WIDTH-1:0] write_mask_i,
  output logic                  v_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  yumi_i
);
  localparam int BANK_W = (NUM_BANKS > 1) ? (ADDR_WIDTH - MACRO_ADDR_WIDTH) : 1;
  localparam int PAD_W  = MASK_WIDTH * MACRO_WIDTH;
`ifdef HARD_MEM_WRITE_ACK_EN
  localparam logic WRITE_ACK = 1'b1;
`else
  localparam logic WRITE_ACK = 1'b0;
`endif

  logic                        accept;
  logic [BANK_W-1:0]           bank;
  logic [MACRO_ADDR_WIDTH-1:0] macro_addr;
  logic [PAD_W-1:0]            data_pad;
  logic [PAD_W-1:0]            rd_pad;
  logic [DATA_WIDTH-1:0]       resp_data;
  logic [MACRO_WIDTH-1:0]      dout        [NUM_BANKS][MASK_WIDTH];
  logic [MACRO_WIDTH-1:0]      unused_dout1 [NUM_BANKS][MASK_WIDTH];
  logic                        unused_pad;

  logic                  rd_pend_q, rd_pend_d;
  logic                  wack_q, wack_d;
  logic [BANK_W-1:0]     bank_sel_q, bank_sel_d;
  logic                  hold_v_q, hold_v_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  generate
    if (NUM_BANKS > 1) begin : g_bank_dec
      assign bank = addr_i[ADDR_WIDTH-1:MACRO_ADDR_WIDTH];
    end else begin : g_bank_one
      assign bank = '0;
    end
  endgenerate

  assign macro_addr = addr_i[MACRO_ADDR_WIDTH-1:0];
  assign data_pad   = PAD_W'(data_i);
  // A response that is not taken this cycle blocks new requests until yumi.
  assign ready_o    = ~reset_i & ~hold_v_q & ~(rd_pend_q & ~yumi_i);
  assign accept     = v_i & ready_o;

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      for (genvar k = 0; k < MASK_WIDTH; k++) begin : g_col
        sky130_sram_1kbyte_1rw1r_8x1024_8 u_macro (
          .clk0   (clk_i),
          .csb0   (~(accept & (bank == BANK_W'(b)))),
          .web0   (~w_i),
          .wmask0 (write_mask_i[k]),
          .addr0  (macro_addr),
          .din0   (data_pad[k*MACRO_WIDTH +: MACRO_WIDTH]),
          .dout0  (dout[b][k]),
          .clk1   (clk_i),
          .csb1   (1'b1),
          .addr1  ('0),
          .dout1  (unused_dout1[b][k])
        );
      end
    end
  endgenerate

  always_comb begin
    rd_pad = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel_q == BANK_W'(b)) begin
        for (int k = 0; k < MASK_WIDTH; k++) begin
          rd_pad[k*MACRO_WIDTH +: MACRO_WIDTH] = dout[b][k];
        end
      end
    end
  end

  assign unused_pad = ^rd_pad;
  assign resp_data  = wack_q ? '0 : rd_pad[DATA_WIDTH-1:0];
  assign v_o        = hold_v_q | rd_pend_q;
  assign data_o     = hold_v_q ? hold_data_q : resp_data;

  always_comb begin
    rd_pend_d   = accept & (~w_i | WRITE_ACK);
    wack_d      = accept & w_i & WRITE_ACK;
    bank_sel_d  = bank_sel_q;
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    if (accept) bank_sel_d = bank;
    if (rd_pend_q & ~yumi_i) begin
      hold_v_d    = 1'b1;
      hold_data_d = resp_data;
    end else if (yumi_i) begin
      hold_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_pend_q   <= 1'b0;
      wack_q      <= 1'b0;
      bank_sel_q  <= '0;
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      wack_q      <= wack_d;
      bank_sel_q  <= bank_sel_d;
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
    end
  end
endmodule
